phase_accumulator_ser: RTL and testbench

- Parametrised next-generation NCO phase accumulator. It feeds the quarter-wave amplitude LUT through a narrow serial address bus.
- Each frame of F = ADDR_W/SER_W + 1 cycles it performs these steps:
  - accumulates FCW;
  - applies a phase offset;
  - folds the phase into a quarter-wave address plus a sign bit;
  - streams the address out SER_W bits per cycle.
- It adds a glitch-free FCW update handshake and deterministic idle output.

---
 rtl/phase_accumulator_ser_if.sv | 16 +
 rtl/phase_accumulator_ser.sv | 70 +++++++
 tb/tb_phase_accumulator_ser.sv | 96 +++++++++
 3 files changed

// File: rtl/phase_accumulator_ser_if.sv
// phase_accumulator_ser_if: FCW handshake, phase offset and serial LUT address bus of the NCO.
interface phase_accumulator_ser_if #(
  parameter int ACC_W = 20,
  parameter int SER_W = 2
);
  logic [ACC_W-1:0] FCW_in;
  logic             FCW_wr;
  logic             FCW_pend;
  logic [ACC_W-1:0] POFF;
  logic             Vld;
  logic             Frm;
  logic [SER_W-1:0] Aout;
  logic             ISout;
  modport master (output FCW_in, FCW_wr, POFF, input FCW_pend, Vld, Frm, Aout, ISout);
  modport slave  (input FCW_in, FCW_wr, POFF, output FCW_pend, Vld, Frm, Aout, ISout);
endinterface

// File: rtl/phase_accumulator_ser.sv
// phase_accumulator_ser: framed NCO phase accumulator streaming a folded quarter-wave address serially.
// Optional PHASE_DITHER_EN adds LFSR dither below the phase truncation point.
module phase_accumulator_ser #(
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 10,
  parameter int SER_W  = 2,
  parameter int DITH_W = 4
) (
  input logic clk,
  input logic En,
  phase_accumulator_ser_if.slave bus
);
  localparam int F  = ADDR_W / SER_W + 1;
  localparam int SW = $clog2(F);
  if (ADDR_W > ACC_W - 2 || ADDR_W % SER_W != 0 || DITH_W > ACC_W - 2 - ADDR_W) begin : g_bad_params
    $error("phase_accumulator_ser: inconsistent parameters");
  end
  logic [SW-1:0]            slot;
  logic [ACC_W-1:0]         acc, fcw_act, shadow, ph;
  logic                     pend, sign_reg, last;
  logic [ADDR_W-1:0]        addr_reg, raw;
  logic [1:0]               q;
  logic [ADDR_W+SER_W-1:0]  addr_ext;
  assign last = slot == SW'(F - 1);
`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr;
  assign ph = acc + bus.POFF + ACC_W'(lfsr[DITH_W-1:0]);
  always_ff @(posedge clk)
    if (!En) lfsr <= 16'hACE1;
    else if (last) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
  assign ph = acc + bus.POFF;
`endif
  assign q   = ph[ACC_W-1 -: 2];
  assign raw = ADDR_W'(ph >> (ACC_W - 2 - ADDR_W));
  // The zero chunk above the address makes the last slot emit 0 without a special case.
  assign addr_ext     = {SER_W'(0), addr_reg};
  assign bus.Aout     = addr_ext[SER_W*slot +: SER_W];
  assign bus.Vld      = last;
  assign bus.Frm      = slot == '0;
  assign bus.ISout    = sign_reg;
  assign bus.FCW_pend = pend;
  always_ff @(posedge clk) begin
    if (!En) begin
      slot     <= '0;
      acc      <= '0;
      fcw_act  <= '0;
      shadow   <= '0;
      pend     <= 1'b0;
      addr_reg <= '0;
      sign_reg <= 1'b0;
    end else begin
      slot <= last ? '0 : slot + 1'b1;
      if (last) begin
        addr_reg <= q[0] ? ~raw : raw;
        sign_reg <= q[1];
        acc      <= acc + fcw_act;
        if (pend) begin
          fcw_act <= shadow;
          pend    <= 1'b0;
        end
      end
      // A write in the boundary cycle still hands the old shadow over; the new word waits a frame.
      if (bus.FCW_wr) begin
        shadow <= bus.FCW_in;
        pend   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phase_accumulator_ser.sv
// tb_phase_accumulator_ser: directed frame-by-frame checks of timing, folding, wrap and FCW handshake.
module tb_phase_accumulator_ser;
  logic clk = 1'b0;
  logic en;
  int   total = 0, passes = 0, fails = 0;
  phase_accumulator_ser_if #(.ACC_W(20), .SER_W(2)) bus ();
  phase_accumulator_ser dut (.clk(clk), .En(en), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Checks one whole frame starting at slot 0; optional writes at slots sa/sb (use 9 for none).
  task automatic frame(input string tag, input logic [9:0] addr, input logic sign, input logic pend4,
                       input int sa, input logic [19:0] va, input int sb, input logic [19:0] vb);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s.aout%0d", tag, k), 32'(bus.Aout), k < 5 ? 32'((addr >> (2 * k)) & 10'd3) : 32'd0);
      chk($sformatf("%s.sign%0d", tag, k), 32'(bus.ISout), 32'(sign));
      chk($sformatf("%s.vld%0d", tag, k), 32'(bus.Vld), 32'(k == 5));
      chk($sformatf("%s.frm%0d", tag, k), 32'(bus.Frm), 32'(k == 0));
      if (k == 4) chk($sformatf("%s.pend", tag), 32'(bus.FCW_pend), 32'(pend4));
      bus.FCW_wr = (k == sa) || (k == sb);
      bus.FCW_in = (k == sb) ? vb : va;
      tick();
      bus.FCW_wr = 1'b0;
    end
  endtask
  initial begin
    en = 1'b0;
    bus.FCW_wr = 1'b0;
    bus.FCW_in = '0;
    bus.POFF = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.FCW_wr = 1'b1;
        bus.FCW_in = 20'hFFFFF;
      end
      tick();
      chk("rst.aout", 32'(bus.Aout), 0);
      chk("rst.sign", 32'(bus.ISout), 0);
      chk("rst.vld", 32'(bus.Vld), 0);
      chk("rst.frm", 32'(bus.Frm), 1);
      chk("rst.pend", 32'(bus.FCW_pend), 0);
    end
    bus.FCW_wr = 1'b0;
    en = 1'b1;
    frame("f0", 10'h000, 1'b0, 1'b1, 0, 20'h00100, 9, 20'h0);
    chk("f1.pend0", 32'(bus.FCW_pend), 0);
    frame("f1", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("f2", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("f3", 10'h001, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("f4", 10'h002, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    chk("f5.aout0", 32'(bus.Aout), 3);
    tick();
    chk("f5.aout1", 32'(bus.Aout), 0);
    tick();
    chk("f5.frm2", 32'(bus.Frm), 0);
    tick();
    en = 1'b0;
    tick();
    chk("mid.aout", 32'(bus.Aout), 0);
    chk("mid.frm", 32'(bus.Frm), 1);
    chk("mid.vld", 32'(bus.Vld), 0);
    chk("mid.pend", 32'(bus.FCW_pend), 0);
    en = 1'b1;
    bus.POFF = 20'h40000;
    frame("r0", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    bus.POFF = 20'h80000;
    frame("q1", 10'h3FF, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    bus.POFF = 20'hC0100;
    frame("q2", 10'h000, 1'b1, 1'b0, 9, 20'h0, 9, 20'h0);
    bus.POFF = 20'h00000;
    frame("q3", 10'h3FE, 1'b1, 1'b1, 0, 20'h80000, 9, 20'h0);
    frame("wa", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("wb", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("wc", 10'h000, 1'b1, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("wd", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("ab", 10'h000, 1'b1, 1'b1, 1, 20'h40000, 3, 20'h00400);
    frame("hf", 10'h000, 1'b0, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("hg", 10'h000, 1'b1, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("hh", 10'h004, 1'b1, 1'b0, 5, 20'h01000, 9, 20'h0);
    frame("hi", 10'h008, 1'b1, 1'b1, 9, 20'h0, 9, 20'h0);
    frame("hj", 10'h00C, 1'b1, 1'b0, 9, 20'h0, 9, 20'h0);
    frame("hk", 10'h010, 1'b1, 1'b0, 9, 20'h0, 9, 20'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
